// File: rtl/pipe_load_wb.sv
// Three-stage load/transform/write-back pipeline: S1 latches the request, S2 reads
// the data memory, S3 transforms the word, writes the register bank and drives out_*.
module pipe_load_wb #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   // Handshake: a request transfers on a rising edge where in_valid=1 and in_ready=1;
   // in_ready is simply ~stall, and a request presented while rst=1 is dropped.
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [3:0]        in_func,
   input  logic              stall,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [REG_AW-1:0] rb_raddr,
   output logic [DATA_W-1:0] rb_rdata,
   output logic              out_valid,
   output logic [REG_AW-1:0] out_rd,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic              busy
);

   localparam int MEM_DEPTH = 1 << ADDR_W;
   localparam int NUM_REGS  = 1 << REG_AW;

   logic [DATA_W-1:0] mem     [MEM_DEPTH];
   logic [DATA_W-1:0] regbank [NUM_REGS];

   logic              s1_v;
   logic [ADDR_W-1:0] s1_addr;
   logic [REG_AW-1:0] s1_rd;
   logic [3:0]        s1_func;

   logic              s2_v;
   logic [DATA_W-1:0] s2_data;
   logic [REG_AW-1:0] s2_rd;
   logic [3:0]        s2_func;

   logic [DATA_W-1:0] xf_data;
   logic [DATA_W-1:0] xf_swap;
   logic              xf_err;
   logic              wb_en;

   assign in_ready = ~stall;
   assign busy     = s1_v | s2_v | out_valid;
   assign rb_rdata = regbank[rb_raddr];

   // Preload port is independent of stall and reset, so memory survives both.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      xf_data = '0;
      xf_err  = 1'b0;
      xf_swap = s2_data;
      xf_swap[15:0] = {s2_data[7:0], s2_data[15:8]};
      case (s2_func)
         4'd0:    xf_data = s2_data;
         4'd1:    xf_data = {DATA_W{1'b0}} - s2_data;
         4'd2:    xf_data = s2_data >> 1;
         4'd3:    xf_data = s2_data << 1;
         4'd4:    xf_data = xf_swap;
         4'd5:    xf_data = {{(DATA_W-8){1'b0}}, s2_data[7:0]};
         4'd6:    xf_data = {{(DATA_W-8){s2_data[7]}}, s2_data[7:0]};
         4'd7:    xf_data = ~s2_data;
         default: xf_err  = 1'b1;
      endcase
   end

   assign wb_en = s2_v & ~stall & ~xf_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v      <= 1'b0;
         s2_v      <= 1'b0;
         out_valid <= 1'b0;
         out_err   <= 1'b0;
         out_rd    <= '0;
         out_data  <= '0;
      end else if (!stall) begin
         s1_v      <= in_valid;
         s1_addr   <= in_addr;
         s1_rd     <= in_rd;
         s1_func   <= in_func;
         // Nonblocking read: a same-edge preload to this address is seen next time.
         s2_v      <= s1_v;
         s2_data   <= mem[s1_addr];
         s2_rd     <= s1_rd;
         s2_func   <= s1_func;
         out_valid <= s2_v;
         out_rd    <= s2_rd;
         out_data  <= xf_data;
         out_err   <= s2_v & xf_err;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regbank[i] <= '0;
         end
      end else if (wb_en) begin
         regbank[s2_rd] <= xf_data;
      end
   end

endmodule
